// File: rtl/wts_channel_mixer_5ch.sv
// Five-channel wave mixer: scales each slot's wave sample by its channel volume,
// sums one slot frame and emits a saturated, shifted mix sample per frame.
// Optional offset-binary output: define WTS_MIXER_UNSIGNED_OUT_EN.
module wts_channel_mixer_5ch #(
  parameter int OUT_BITS = 11,
  parameter int SHIFT    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          active,
  input  logic [7:0]          wave_data,
  input  logic                wave_data_valid,
  input  logic [3:0]          reg_volume_a,
  input  logic [3:0]          reg_volume_b,
  input  logic [3:0]          reg_volume_c,
  input  logic [3:0]          reg_volume_d,
  input  logic [3:0]          reg_volume_e,
  input  logic [4:0]          reg_enable,
  output logic [OUT_BITS-1:0] mix_out,
  output logic                mix_valid
);

  localparam logic [2:0] IDLE_SLOT = 3'd5;
  localparam int         SAT_MAX   = (1 << (OUT_BITS - 1)) - 1;
  localparam int         SAT_MIN   = -(1 << (OUT_BITS - 1));

  localparam logic [OUT_BITS-1:0] POS_LIMIT = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] NEG_LIMIT = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic [OUT_BITS-1:0] MIDSCALE  = {1'b1, {(OUT_BITS-1){1'b0}}};

`ifdef WTS_MIXER_UNSIGNED_OUT_EN
  localparam logic [OUT_BITS-1:0] MIX_OFFSET = MIDSCALE;
`else
  localparam logic [OUT_BITS-1:0] MIX_OFFSET = '0;
`endif

  logic [2:0]         last_active_q;
  logic [4:0]         done_mask;
  logic signed [11:0] p_q;
  logic               p_valid_q;
  logic signed [14:0] acc;

  logic               slot_is_chan;
  logic [4:0]         slot_sel;
  logic [3:0]         vol_sel;
  logic               capture;
  logic               frame_close;
  logic signed [11:0] wave_ext;
  logic signed [11:0] vol_ext;
  logic signed [11:0] product;
  logic signed [14:0] p_ext;
  logic signed [14:0] frame_sum;
  logic signed [31:0] shifted;
  logic [OUT_BITS-1:0] sat_val;
  logic [OUT_BITS-1:0] mix_next;

  assign slot_is_chan = (active < IDLE_SLOT);
  assign slot_sel     = slot_is_chan ? 5'(5'b00001 << active) : 5'b00000;
  // A slot captures only once per frame; disabled slots never mark themselves done.
  assign capture      = wave_data_valid && |(slot_sel & reg_enable & ~done_mask);
  assign frame_close  = !slot_is_chan && (last_active_q < IDLE_SLOT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    vol_sel = 4'd0;
    case (active)
      3'd0:    vol_sel = reg_volume_a;
      3'd1:    vol_sel = reg_volume_b;
      3'd2:    vol_sel = reg_volume_c;
      3'd3:    vol_sel = reg_volume_d;
      3'd4:    vol_sel = reg_volume_e;
      default: vol_sel = 4'd0;
    endcase
  end

  // Volume is unsigned, so it is zero-extended before the signed multiply.
  assign wave_ext = {{4{wave_data[7]}}, wave_data};
  assign vol_ext  = {8'd0, vol_sel};
  assign product  = wave_ext * vol_ext;

  assign p_ext     = {{3{p_q[11]}}, p_q};
  assign frame_sum = acc + (p_valid_q ? p_ext : 15'sd0);
  assign shifted   = $signed({{17{frame_sum[14]}}, frame_sum}) >>> SHIFT;

  always_comb begin
    sat_val = shifted[OUT_BITS-1:0];
    if (shifted > SAT_MAX)      sat_val = POS_LIMIT;
    else if (shifted < SAT_MIN) sat_val = NEG_LIMIT;
  end

  assign mix_next = sat_val + MIX_OFFSET;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_active_q <= IDLE_SLOT;
      done_mask     <= 5'd0;
      p_q           <= 12'sd0;
      p_valid_q     <= 1'b0;
      acc           <= 15'sd0;
      mix_out       <= MIX_OFFSET;
      mix_valid     <= 1'b0;
    end else begin
      last_active_q <= active;
      p_valid_q     <= capture;
      mix_valid     <= 1'b0;
      if (capture) begin
        p_q       <= product;
        done_mask <= done_mask | slot_sel;
      end
      // Close folds in any pending product, so it never leaks into the next frame.
      if (frame_close) begin
        acc       <= 15'sd0;
        done_mask <= 5'd0;
        mix_out   <= mix_next;
        mix_valid <= 1'b1;
      end else if (p_valid_q) begin
        acc <= acc + p_ext;
      end
    end
  end

endmodule

// File: tb/tb_wts_channel_mixer_5ch.sv
// Self-checking bench for wts_channel_mixer_5ch: directed test-plan frames plus
// random traffic, compared every cycle against a frame-level arithmetic model.
module tb_wts_channel_mixer_5ch;

  localparam int OUT_BITS = 11;
  localparam int SHIFT    = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [2:0]          active = 3'd5;
  logic [7:0]          wave_data = 8'd0;
  logic                wave_data_valid = 1'b0;
  logic [3:0]          vol [5];
  logic [4:0]          reg_enable = 5'd0;
  logic [OUT_BITS-1:0] mix_out;
  logic                mix_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level reference: running sum of first enabled sample per slot.
  int                  m_sum;
  logic [4:0]          m_done;
  int                  m_prev;
  logic [OUT_BITS-1:0] m_out;
  logic                m_valid;

  wts_channel_mixer_5ch #(.OUT_BITS(OUT_BITS), .SHIFT(SHIFT)) dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .wave_data       (wave_data),
    .wave_data_valid (wave_data_valid),
    .reg_volume_a    (vol[0]),
    .reg_volume_b    (vol[1]),
    .reg_volume_c    (vol[2]),
    .reg_volume_d    (vol[3]),
    .reg_volume_e    (vol[4]),
    .reg_enable      (reg_enable),
    .mix_out         (mix_out),
    .mix_valid       (mix_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_BITS-1:0] fmt(input int v);
`ifdef WTS_MIXER_UNSIGNED_OUT_EN
    return OUT_BITS'(v + (1 << (OUT_BITS - 1)));
`else
    return OUT_BITS'(v);
`endif
  endfunction

  function automatic logic [OUT_BITS-1:0] expect_mix(input int sum);
    int s;
    s = sum >>> SHIFT;
    if (s > (1 << (OUT_BITS - 1)) - 1) s = (1 << (OUT_BITS - 1)) - 1;
    if (s < -(1 << (OUT_BITS - 1)))    s = -(1 << (OUT_BITS - 1));
    return fmt(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_edge(input logic [2:0] act, input logic vld, input logic [7:0] dat,
                            input logic rst);
    if (rst) begin
      m_sum = 0; m_done = 5'd0; m_prev = 5; m_out = fmt(0); m_valid = 1'b0;
    end else begin
      m_valid = (act >= 3'd5) && (m_prev < 5);
      if (m_valid) begin
        m_out  = expect_mix(m_sum);
        m_sum  = 0;
        m_done = 5'd0;
      end else if (vld && act < 3'd5 && reg_enable[act] && !m_done[act]) begin
        m_sum      = m_sum + int'($signed(dat)) * int'(vol[act]);
        m_done[act] = 1'b1;
      end
      m_prev = int'(act);
    end
  endtask

  task automatic step(input logic [2:0] act, input logic vld, input logic [7:0] dat,
                      input logic rst);
    active = act; wave_data_valid = vld; wave_data = dat; reset = rst;
    @(posedge clk);
    model_edge(act, vld, dat, rst);
    @(negedge clk);
    check("mix_valid", 32'(mix_valid), 32'(m_valid));
    check("mix_out", 32'(mix_out), 32'(m_out));
  endtask

  task automatic set_vols(input logic [3:0] v);
    for (int i = 0; i < 5; i++) vol[i] = v;
  endtask

  initial begin
    set_vols(4'd0);
    model_edge(3'd5, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    step(3'd5, 1'b0, 8'd0, 1'b1);
    step(3'd5, 1'b0, 8'd0, 1'b1);
    check("reset_mix_out", 32'(mix_out), 32'(fmt(0)));
    check("reset_mix_valid", 32'(mix_valid), 32'd0);

    // Single channel gain path.
    reg_enable = 5'b00001; vol[0] = 4'd8;
    step(3'd0, 1'b1, 8'd64, 1'b0);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("single_a", 32'(mix_out), 32'(fmt(64)));
    check("single_a_pulse", 32'(mix_valid), 32'd1);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("idle_no_repulse", 32'(mix_valid), 32'd0);

    // Positive saturation.
    reg_enable = 5'b11111; set_vols(4'd15);
    for (int s = 0; s < 5; s++) step(3'(s), 1'b1, 8'd127, 1'b0);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("pos_sat", 32'(mix_out), 32'(fmt(1023)));

    // Negative saturation.
    for (int s = 0; s < 5; s++) step(3'(s), 1'b1, 8'h80, 1'b0);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("neg_sat", 32'(mix_out), 32'(fmt(-1024)));

    // Mute and duplicate.
    reg_enable = 5'b00001;
    step(3'd0, 1'b1, 8'd16, 1'b0);
    step(3'd0, 1'b1, 8'd16, 1'b0);
    step(3'd1, 1'b1, 8'd100, 1'b0);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("mute_dup", 32'(mix_out), 32'(fmt(30)));

    // Empty frame still pulses, using idle code 7.
    step(3'd2, 1'b0, 8'd0, 1'b0);
    step(3'd7, 1'b0, 8'd0, 1'b0);
    check("empty_frame", 32'(mix_out), 32'(fmt(0)));
    check("empty_frame_pulse", 32'(mix_valid), 32'd1);

    // Reset mid-frame, then long idle, then a small negative frame.
    reg_enable = 5'b11111; set_vols(4'd9);
    for (int s = 0; s < 3; s++) step(3'(s), 1'b1, 8'd50, 1'b0);
    step(3'd3, 1'b1, 8'd50, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(3'd5, 1'b0, 8'd0, 1'b0);
      check("idle_after_reset", 32'(mix_valid), 32'd0);
    end
    reg_enable = 5'b00001; vol[0] = 4'd1;
    step(3'd0, 1'b1, 8'hF8, 1'b0);
    step(3'd5, 1'b0, 8'd0, 1'b0);
    check("after_reset_frame", 32'(mix_out), 32'(fmt(-1)));

    // Random traffic with mid-frame volume/enable changes and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < 5; c++) vol[c] = 4'($urandom_range(0, 15));
        reg_enable = 5'($urandom_range(0, 31));
      end
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wts_channel_mixer_5ch.md
Name: wts_channel_mixer_5ch

Overview:
Downstream stage of the 5-channel tone generator. Each channel slot's wave RAM sample, read at that slot's wave address, arrives here. The block scales it by the channel volume, accumulates the five channels over one slot frame, then emits one saturated, shifted mixed sample per frame. Its output feeds the sound output/DAC interface.

Parameters:
OUT_BITS, 11, width of mix_out (signed two's complement unless the optional feature is enabled).
SHIFT, 3, arithmetic right shift applied to the 15-bit frame sum before saturation.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
active  input  3  current slot index: 0..4 = channel A..E, 5 = idle slot; 6 and 7 are treated as idle
wave_data  input  8  signed wave sample for slot `active`
wave_data_valid  input  1  wave_data valid for slot `active` this cycle
reg_volume_a..reg_volume_e  input  4 each  unsigned channel volume, 0..15
reg_enable  input  5  per-channel enable, bit0 = A … bit4 = E
mix_out  output  OUT_BITS  mixed sample, held between frames
mix_valid  output  1  one-cycle pulse when mix_out updates

Behaviour:
- Single clock domain. Reset is synchronous and active-high; nothing is asynchronous.
- State:
  - last_active_q (3b)
  - done_mask (5b)
  - product register p_q (12b signed) and p_valid_q
  - accumulator acc (15b signed)
  - mix_out, mix_valid
- Reset values:
  - acc=0, p_q=0, p_valid_q=0, done_mask=0
  - last_active_q=5
  - mix_valid=0
  - mix_out=0 (midscale 2^(OUT_BITS-1) when the optional feature is enabled)
- Stage 1, capture: on an edge with wave_data_valid=1, active∈0..4, reg_enable[active]=1 and done_mask[active]=0:
  - p_q <= signed(wave_data) × unsigned(reg_volume[active]), 12-bit signed, range -1920..1905
  - p_valid_q <= 1
  - done_mask[active] <= 1
  - Otherwise p_valid_q <= 0.
- Duplicate valid for a slot already done in the current frame: ignored, no accumulation.
- Disabled channel: ignored, but its done bit is not set.
- Volume 0: contributes 0; still counts as captured.
- Stage 2, accumulate: on an edge with p_valid_q=1, acc <= acc + sign-extended p_q. The 15-bit range covers the worst case of -9600 with no overflow.
- Frame close: on the first edge where active≥5 and last_active_q<5:
  - sum = acc + (p_valid_q ? p_q : 0)
  - mix_out <= sat(sum >>> SHIFT) into the signed OUT_BITS range [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]
  - acc <= 0, done_mask <= 0
  - mix_valid <= 1 for exactly one cycle
  - A product pending at the close edge is consumed by the close and is not added to the next frame.
- last_active_q <= active on every edge.
- Latency: the last channel sample captured at edge k appears in mix_out after edge k+1 at the earliest, i.e. on the next close edge.
- A frame containing no valid samples closes with mix_out=0 (or midscale) and still pulses mix_valid.
- Repeated idle cycles (active held at 5): only the first produces a close.
- Reset mid-frame: the partial sum is discarded. The first close after reset needs active to go <5 and then back to 5.
- Volume or enable changes take effect on the next capture; already-captured products are unaffected.

Optional Feature:
WTS_MIXER_UNSIGNED_OUT_EN
- Defined: after saturation, mix_out = saturated value + 2^(OUT_BITS-1), i.e. offset binary 0..2^OUT_BITS-1 for unsigned DACs. Reset and empty-frame value is midscale.
- Undefined: mix_out is signed two's complement. Reset and empty-frame value is 0.

Test Plan:
- Single channel, gain path: A only enabled, vol_a=8, wave_data=64 in slot 0, then active→5 → one mix_valid pulse, mix_out=64 (512>>>3).
- Positive saturation: all enabled, all vol=15, wave_data=127 in slots 0..4 → sum 9525>>>3=1190 → mix_out=1023.
- Negative saturation: same setup with -128 in every slot → mix_out=-1024.
- Mute and duplicate: reg_enable=5'b00001; slot 0 sends 16 twice at vol 15; slot 1 sends 100 → mix_out=30 (240>>>3). Disabled slot and second slot-0 sample are ignored.
- Reset and idle: assert reset mid-frame after slot 2; keep active=5 for 10 cycles after reset → no mix_valid. Then run one frame with A=-8, vol 1 → mix_out=-1.
- With WTS_MIXER_UNSIGNED_OUT_EN: after reset mix_out=1024; rerun the first scenario → mix_out=1088.
